// File: rtl/avg_frame_buf.sv
// Purpose: holds one ROWS x COLS frame of averaged 8-bit pixels and serves random reads once the frame is complete.
// Latency: each write lands in one cycle; rd_req gives rd_valid/rd_data on the next cycle; frame_done rises the cycle after the last write.
// Backpressure: none. Samples that arrive while a frame is held are dropped and latch sticky overflow. Optional AVG_ROWSUM_EN adds per-row sums.
module avg_frame_buf #(
    parameter int ROWS = 15,
    parameter int COLS = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       frame_ack,
    input  logic       rd_req,
    input  logic [6:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       frame_done,
    output logic       overflow
`ifdef AVG_ROWSUM_EN
    ,
    output logic [10:0] row_sum,
    output logic        row_sum_valid
`endif
);

    localparam int         DEPTH  = ROWS * COLS;
    localparam logic [6:0] LAST   = 7'(DEPTH - 1);
    localparam logic [7:0] DEPTH8 = 8'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_FULL
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [6:0] r_wr_ptr;
    logic [7:0] r_mem [DEPTH];
    logic       w_wr_en;
    logic       w_ack;
    logic       w_rd_hit;
    logic       w_rd_in_range;

    // An ack only counts while a frame is held; in IDLE/FILL it is ignored.
    assign w_ack         = (r_state == S_FULL) && frame_ack;
    assign w_rd_hit      = (r_state == S_FULL) && rd_req;
    assign w_rd_in_range = ({1'b0, rd_addr} < DEPTH8);
    assign frame_done    = (r_state == S_FULL);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and write enable: accept samples until the last slot is written, then hold until acked.
    always_comb begin
        w_next  = r_state;
        w_wr_en = 1'b0;
        case (r_state)
            S_IDLE, S_FILL: begin
                if (in_valid) begin
                    w_wr_en = 1'b1;
                    w_next  = (r_wr_ptr == LAST) ? S_FULL : S_FILL;
                end
            end
            S_FULL: begin
                if (frame_ack) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Write pointer: advances per accepted sample, rewinds when the held frame is released.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= 7'd0;
        end else if (w_ack) begin
            r_wr_ptr <= 7'd0;
        end else if (w_wr_en) begin
            r_wr_ptr <= r_wr_ptr + 7'd1;
        end
    end

    // Pixel storage; contents survive reset and ack, only the pointer is rewound.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    // Sticky overflow: any sample seen while a frame is held, including the ack cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if ((r_state == S_FULL) && in_valid) begin
            overflow <= 1'b1;
        end
    end

    // Registered read port: data only for reads issued while FULL; out-of-range addresses return zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_valid <= 1'b0;
            rd_data  <= 8'h00;
        end else begin
            rd_valid <= w_rd_hit;
            if (w_rd_hit && w_rd_in_range) begin
                rd_data <= r_mem[rd_addr];
            end else begin
                rd_data <= 8'h00;
            end
        end
    end

`ifdef AVG_ROWSUM_EN
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

    logic [CW-1:0] r_col;
    logic [10:0]   r_acc;
    logic [10:0]   w_sum;

    assign w_sum = r_acc + 11'(in_data);

    // Row accumulator: publishes the full row sum the cycle after the row's last pixel is written.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_col         <= '0;
            r_acc         <= 11'd0;
            row_sum       <= 11'd0;
            row_sum_valid <= 1'b0;
        end else begin
            row_sum_valid <= 1'b0;
            if (w_ack) begin
                r_col <= '0;
                r_acc <= 11'd0;
            end else if (w_wr_en) begin
                if (r_col == CW'(COLS - 1)) begin
                    row_sum       <= w_sum;
                    row_sum_valid <= 1'b1;
                    r_col         <= '0;
                    r_acc         <= 11'd0;
                end else begin
                    r_col <= r_col + 1'b1;
                    r_acc <= w_sum;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_avg_frame_buf.sv
// Purpose: randomized bench for avg_frame_buf against a frame-level reference model.
// Latency: compares every output one cycle after each stimulus step, plus directed reads.
// Backpressure: n/a; the bench drives every cycle. Row-sum outputs are checked when AVG_ROWSUM_EN is defined.
module tb_avg_frame_buf;

    localparam int ROWS  = 15;
    localparam int COLS  = 8;
    localparam int DEPTH = ROWS * COLS;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       frame_ack = 1'b0;
    logic       rd_req = 1'b0;
    logic [6:0] rd_addr = 7'd0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       frame_done;
    logic       overflow;
`ifdef AVG_ROWSUM_EN
    logic [10:0] row_sum;
    logic        row_sum_valid;
`endif

    avg_frame_buf #(.ROWS(ROWS), .COLS(COLS)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .frame_ack  (frame_ack),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .frame_done (frame_done),
        .overflow   (overflow)
`ifdef AVG_ROWSUM_EN
        ,
        .row_sum       (row_sum),
        .row_sum_valid (row_sum_valid)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: a picture of the frame, not of the hardware.
    logic [7:0] m_mem [128];
    int         m_cnt  = 0;
    bit         m_full = 0;
    bit         m_ovf  = 0;
    int         m_rsum = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock of stimulus; model advances, then all outputs are compared after the edge.
    task automatic step(input bit v, input logic [7:0] d, input bit ack, input bit rq, input logic [6:0] a);
        bit         exp_rv;
        logic [7:0] exp_rd;
        bit         exp_rsv;
        int         exp_rs;
        exp_rv  = m_full && rq;
        exp_rd  = (m_full && rq && int'(a) < DEPTH) ? m_mem[a] : 8'h00;
        exp_rsv = 0;
        exp_rs  = -1;
        if (m_full) begin
            if (v) m_ovf = 1;
            if (ack) begin
                m_full = 0;
                m_cnt  = 0;
            end
        end else if (v) begin
            m_mem[m_cnt] = d;
            m_rsum += int'(d);
            if (m_cnt % COLS == COLS - 1) begin
                exp_rsv = 1;
                exp_rs  = m_rsum;
                m_rsum  = 0;
            end
            m_cnt++;
            if (m_cnt == DEPTH) m_full = 1;
        end
        in_valid  = v;
        in_data   = d;
        frame_ack = ack;
        rd_req    = rq;
        rd_addr   = a;
        @(posedge clk);
        #1;
        in_valid  = 0;
        frame_ack = 0;
        rd_req    = 0;
        check("rd_valid", 32'(rd_valid), 32'(exp_rv));
        check("rd_data", 32'(rd_data), 32'(exp_rd));
        check("frame_done", 32'(frame_done), 32'(m_full));
        check("overflow", 32'(overflow), 32'(m_ovf));
`ifdef AVG_ROWSUM_EN
        check("row_sum_valid", 32'(row_sum_valid), 32'(exp_rsv));
        if (exp_rsv) check("row_sum", 32'(row_sum), 32'(exp_rs));
`endif
    endtask

    // Asynchronous reset pulse, with outputs checked while reset is still asserted.
    task automatic do_reset();
        reset = 0;
        #2;
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
`ifdef AVG_ROWSUM_EN
        check("rst_row_sum", 32'(row_sum), 32'd0);
        check("rst_row_sum_valid", 32'(row_sum_valid), 32'd0);
`endif
        m_full = 0;
        m_cnt  = 0;
        m_ovf  = 0;
        m_rsum = 0;
        #1;
        reset = 1;
    endtask

    task automatic rand_read(input bit allow);
        step(0, 8'h00, 0, allow && ($urandom_range(0, 2) == 0), 7'($urandom_range(0, 127)));
    endtask

    initial begin
        #3;
        do_reset();
        @(posedge clk);
        #1;

        // Frame of value=index, random gaps and reads while filling.
        for (int i = 0; i < DEPTH; i++) begin
            while ($urandom_range(0, 3) == 0) rand_read(1);
            step(1, 8'(i), 0, $urandom_range(0, 1) == 1, 7'($urandom_range(0, 127)));
            if (i == DEPTH - 2) check("not_done_before_last", 32'(frame_done), 32'd0);
        end
        check("done_after_120", 32'(frame_done), 32'd1);
        step(0, 8'h00, 0, 1, 7'd37);
        check("rd37_valid", 32'(rd_valid), 32'd1);
        check("rd37_data", 32'(rd_data), 32'd37);
        step(0, 8'h00, 0, 1, 7'd120);
        check("rd120_valid", 32'(rd_valid), 32'd1);
        check("rd120_data", 32'(rd_data), 32'd0);
        step(0, 8'h00, 0, 0, 7'd3);
        check("idle_rd_valid", 32'(rd_valid), 32'd0);

        // Extra sample while FULL is dropped.
        step(1, 8'hAA, 0, 0, 7'd0);
        check("ovf_set", 32'(overflow), 32'd1);
        step(0, 8'h00, 0, 1, 7'd0);
        check("rd0_after_ovf", 32'(rd_data), 32'd0);

        // Ack + sample + read in one cycle.
        step(1, 8'h55, 1, 1, 7'd5);
        check("ack_rd_data", 32'(rd_data), 32'd5);
        check("ack_idle", 32'(frame_done), 32'd0);
        check("ack_ovf", 32'(overflow), 32'd1);
        step(1, 8'h77, 0, 0, 7'd0);
        for (int i = 1; i < DEPTH; i++) begin
            step(1, 8'($urandom), ($urandom_range(0, 9) == 0), $urandom_range(0, 3) == 0, 7'($urandom_range(0, 127)));
        end
        step(0, 8'h00, 0, 1, 7'd0);
        check("ack_next_at0", 32'(rd_data), 32'h77);
        for (int a = 0; a < 128; a += 7) step(0, 8'h00, 0, 1, 7'(a));
        step(0, 8'h00, 1, 0, 7'd0);

        // Partial frame discarded by reset.
        for (int i = 0; i < 50; i++) step(1, 8'($urandom), 0, 0, 7'd0);
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1, 8'h11, 0, 0, 7'd0);
        check("rst_refill_done", 32'(frame_done), 32'd1);
        step(0, 8'h00, 0, 1, 7'd0);
        check("rst_refill_rd0", 32'(rd_data), 32'h11);
        step(0, 8'h00, 1, 0, 7'd0);

        // All-0xFF frame exercises the widest row sums.
        for (int i = 0; i < DEPTH; i++) begin
            step(1, 8'hFF, 0, 0, 7'd0);
`ifdef AVG_ROWSUM_EN
            if (i == COLS - 1) begin
                check("rowsum_ff_valid", 32'(row_sum_valid), 32'd1);
                check("rowsum_ff", 32'(row_sum), 32'd2040);
            end
`endif
        end
        step(0, 8'h00, 0, 1, 7'd119);
        check("ff_rd119", 32'(rd_data), 32'hFF);

        // Fully random traffic.
        for (int c = 0; c < 1500; c++) begin
            step($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 19) == 0,
                 $urandom_range(0, 2) == 0, 7'($urandom_range(0, 127)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
